// File: rtl/melody_player_if.sv
// rtl/melody_player_if.sv - note-table write port, playback control and tone outputs of melody_player
interface melody_player_if #(
    parameter int AW = 4
);
    logic          wr_en;
    logic [AW-1:0] wr_addr;
    logic [31:0]   wr_freq;
    logic [15:0]   wr_dur;
    logic          start;
    logic          stop;
    logic          loop;
    logic [31:0]   freq;
    logic          onOff;
    logic          busy;
    logic          done;
    logic [AW-1:0] note_idx;

    modport master (
        output wr_en, wr_addr, wr_freq, wr_dur, start, stop, loop,
        input  freq, onOff, busy, done, note_idx
    );

    modport slave (
        input  wr_en, wr_addr, wr_freq, wr_dur, start, stop, loop,
        output freq, onOff, busy, done, note_idx
    );
endinterface

// File: rtl/melody_player.sv
// rtl/melody_player.sv - note-table sequencer driving a tone generator
module melody_player #(
    parameter int FCLK    = 50000000,
    parameter int NOTES   = 16,
    parameter int GAP_CYC = FCLK / 50
) (
    input  logic             clk,
    input  logic             reset_n,
    melody_player_if.slave   bus
);
    localparam int AW     = $clog2(NOTES);
    localparam int MS_CYC = FCLK / 1000;
    localparam int PW     = (MS_CYC > 1) ? $clog2(MS_CYC) : 1;
    localparam int GW     = (GAP_CYC > 1) ? $clog2(GAP_CYC) : 1;

    localparam logic [PW-1:0] PRE_LAST = PW'(MS_CYC - 1);
    localparam logic [GW-1:0] GAP_LAST = GW'(GAP_CYC - 1);
    localparam logic [AW-1:0] IDX_LAST = AW'(NOTES - 1);

    typedef enum logic [1:0] {S_IDLE, S_LOAD, S_PLAY, S_GAP} state_t;

    logic [31:0] freq_tab [NOTES];
    logic [15:0] dur_tab  [NOTES];

    state_t        state_q, state_d;
    logic [AW-1:0] idx_q, idx_d;
    logic [31:0]   freq_q, freq_d;
    logic [15:0]   dur_q, dur_d;
    logic [PW-1:0] pre_q, pre_d;
    logic [15:0]   ms_q, ms_d;
    logic [GW-1:0] gap_q, gap_d;
    logic          has_q, has_d;
    logic          done_q, done_d;
    logic          eom;

    // The table has no reset: contents survive reset_n so a restart replays them.
    always_ff @(posedge clk) begin
        if (bus.wr_en) begin
            freq_tab[bus.wr_addr] <= bus.wr_freq;
            dur_tab[bus.wr_addr]  <= bus.wr_dur;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= S_IDLE;
            idx_q   <= '0;
            freq_q  <= '0;
            dur_q   <= '0;
            pre_q   <= '0;
            ms_q    <= '0;
            gap_q   <= '0;
            has_q   <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            freq_q  <= freq_d;
            dur_q   <= dur_d;
            pre_q   <= pre_d;
            ms_q    <= ms_d;
            gap_q   <= gap_d;
            has_q   <= has_d;
            done_q  <= done_d;
        end
    end

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        freq_d  = freq_q;
        dur_d   = dur_q;
        pre_d   = pre_q;
        ms_d    = ms_q;
        gap_d   = gap_q;
        has_d   = has_q;
        done_d  = 1'b0;
        eom     = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (bus.start) begin
                    idx_d   = '0;
                    has_d   = 1'b0;
                    state_d = S_LOAD;
                end
            end
            S_LOAD: begin
                if (dur_tab[idx_q] != 16'd0) begin
                    freq_d  = freq_tab[idx_q];
                    dur_d   = dur_tab[idx_q];
                    pre_d   = '0;
                    ms_d    = '0;
                    has_d   = 1'b1;
                    state_d = S_PLAY;
                end else begin
                    eom = 1'b1;
                end
            end
            S_PLAY: begin
                // Prescaler counts one millisecond; ms_q counts milliseconds of the note.
                if (pre_q == PRE_LAST) begin
                    pre_d = '0;
                    if (ms_q == dur_q - 16'd1) begin
                        ms_d    = '0;
                        gap_d   = '0;
                        state_d = S_GAP;
                    end else begin
                        ms_d = ms_q + 16'd1;
                    end
                end else begin
                    pre_d = pre_q + PW'(1);
                end
            end
            S_GAP: begin
                if (gap_q == GAP_LAST) begin
                    gap_d = '0;
                    if (idx_q == IDX_LAST) begin
                        eom = 1'b1;
                    end else begin
                        idx_d   = idx_q + AW'(1);
                        state_d = S_LOAD;
                    end
                end else begin
                    gap_d = gap_q + GW'(1);
                end
            end
            default: state_d = S_IDLE;
        endcase

        // has_q is cleared on every restart at entry 0, so a pass that finds the
        // marker first never loops forever.
        if (eom) begin
            if (bus.loop && has_q) begin
                idx_d   = '0;
                has_d   = 1'b0;
                state_d = S_LOAD;
            end else begin
                done_d  = 1'b1;
                state_d = S_IDLE;
            end
        end

        if (bus.stop) begin
            state_d = S_IDLE;
            done_d  = 1'b0;
        end
    end

    assign bus.onOff    = (state_q == S_PLAY);
    assign bus.freq     = (state_q == S_IDLE) ? 32'd0 : freq_q;
    assign bus.busy     = (state_q != S_IDLE);
    assign bus.done     = done_q;
    assign bus.note_idx = idx_q;
endmodule

// File: tb/tb_melody_player.sv
// tb/tb_melody_player.sv - randomized and directed checks of melody_player against a timeline model
module tb_melody_player;
    localparam int MS  = 4;
    localparam int GAP = 2;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    always #5 clk = ~clk;

    melody_player_if #(.AW(2)) bus ();

    melody_player #(.FCLK(4000), .NOTES(4), .GAP_CYC(2)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    typedef struct {
        bit          onoff;
        bit          busy;
        bit          done;
        bit          chkf;
        logic [31:0] f;
    } exp_t;

    exp_t        exp_q[$];
    logic [31:0] mf[4];
    int          md[4];
    int          n_checks = 0;
    int          n_fail   = 0;

    function automatic void push(bit on, bit b, bit d, bit cf, logic [31:0] f);
        exp_t e;
        e.onoff = on; e.busy = b; e.done = d; e.chkf = cf; e.f = f;
        exp_q.push_back(e);
    endfunction

    // Expected per-cycle timeline from the cycle after start is sampled.
    function automatic void build(bit lp, int maxlen, int wk, int waddr, logic [31:0] wf, int wd);
        int i = 0;
        bit has = 0;
        bit applied = 0;
        bit eom;
        logic [31:0] cur;
        exp_q.delete();
        while (exp_q.size() < maxlen) begin
            if (wk >= 0 && !applied && exp_q.size() > wk) begin
                mf[waddr] = wf; md[waddr] = wd; applied = 1;
            end
            push(0, 1, 0, 0, 0);
            eom = 0;
            if (md[i] == 0) begin
                eom = 1;
            end else begin
                has = 1;
                cur = mf[i];
                repeat (md[i] * MS) push(1, 1, 0, 1, cur);
                repeat (GAP) push(0, 1, 0, 1, cur);
                if (i == 3) eom = 1;
                else i++;
            end
            if (eom) begin
                if (lp && has) begin
                    i = 0; has = 0;
                end else begin
                    push(0, 0, 1, 1, 0);
                    push(0, 0, 0, 1, 0);
                    break;
                end
            end
        end
        while (exp_q.size() > maxlen) void'(exp_q.pop_back());
        if (wk >= 0 && !applied) begin
            mf[waddr] = wf; md[waddr] = wd;
        end
    endfunction

    task automatic write_entry(int a, logic [31:0] f, int d);
        @(negedge clk);
        bus.wr_en = 1'b1; bus.wr_addr = 2'(a); bus.wr_freq = f; bus.wr_dur = 16'(d);
        @(negedge clk);
        bus.wr_en = 1'b0;
        mf[a] = f; md[a] = d;
    endtask

    task automatic check_trace(string nm, int stop_k, int wk, int waddr, logic [31:0] wf, int wd);
        @(negedge clk);
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        for (int k = 0; k < exp_q.size(); k++) begin
            n_checks++;
            if (bus.onOff !== exp_q[k].onoff || bus.busy !== exp_q[k].busy ||
                bus.done !== exp_q[k].done || (exp_q[k].chkf && bus.freq !== exp_q[k].f)) begin
                n_fail++;
                $display("FAIL %s cycle %0d: onOff/busy/done=%b%b%b freq=%0d, expected %b%b%b freq=%0d",
                         nm, k, bus.onOff, bus.busy, bus.done, bus.freq,
                         exp_q[k].onoff, exp_q[k].busy, exp_q[k].done, exp_q[k].f);
            end
            bus.wr_en = (k == wk);
            if (k == wk) begin
                bus.wr_addr = 2'(waddr); bus.wr_freq = wf; bus.wr_dur = 16'(wd);
            end
            bus.stop = (k == stop_k);
            if (k < exp_q.size() - 1) @(negedge clk);
        end
        @(negedge clk);
        bus.wr_en = 1'b0;
        bus.stop  = 1'b0;
    endtask

    task automatic check_idle_outputs(string nm);
        n_checks++;
        if (bus.onOff !== 1'b0 || bus.busy !== 1'b0 || bus.done !== 1'b0 ||
            bus.freq !== 32'd0 || bus.note_idx !== 2'd0) begin
            n_fail++;
            $display("FAIL %s: onOff/busy/done=%b%b%b freq=%0d idx=%0d, expected 000 freq=0 idx=0",
                     nm, bus.onOff, bus.busy, bus.done, bus.freq, bus.note_idx);
        end
    endtask

    task automatic load_basic();
        write_entry(0, 440, 2);
        write_entry(1, 880, 1);
        write_entry(2, 0, 0);
        write_entry(3, 1234, 3);
    endtask

    task automatic test_reset();
        repeat (2) @(negedge clk);
        check_idle_outputs("reset");
        reset_n = 1'b1;
        @(negedge clk);
        check_idle_outputs("after_release");
    endtask

    task automatic test_normal();
        load_basic();
        build(0, 1000, -1, 0, 0, 0);
        check_trace("normal", -1, -1, 0, 0, 0);
    endtask

    task automatic test_full_table();
        for (int a = 0; a < 4; a++) write_entry(a, 100 * (a + 1), 1);
        build(0, 1000, -1, 0, 0, 0);
        check_trace("full_table", -1, -1, 0, 0, 0);
    endtask

    task automatic test_loop_stop();
        load_basic();
        bus.loop = 1'b1;
        build(1, 31, -1, 0, 0, 0);
        repeat (3) push(0, 0, 0, 1, 0);
        check_trace("loop_stop", 30, -1, 0, 0, 0);
        bus.loop = 1'b0;
    endtask

    task automatic test_marker_loop();
        write_entry(0, 777, 0);
        bus.loop = 1'b1;
        build(1, 1000, -1, 0, 0, 0);
        check_trace("marker_loop", -1, -1, 0, 0, 0);
        bus.loop = 1'b0;
    endtask

    task automatic test_start_stop();
        load_basic();
        @(negedge clk);
        bus.start = 1'b1; bus.stop = 1'b1;
        @(negedge clk);
        bus.start = 1'b0; bus.stop = 1'b0;
        check_idle_outputs("start_stop_1");
        @(negedge clk);
        check_idle_outputs("start_stop_2");
    endtask

    task automatic test_midwrite();
        load_basic();
        bus.loop = 1'b1;
        build(1, 26, 3, 0, 1000, 1);
        repeat (3) push(0, 0, 0, 1, 0);
        check_trace("midwrite", 25, 3, 0, 1000, 1);
        bus.loop = 1'b0;
    endtask

    task automatic test_async_reset();
        load_basic();
        @(negedge clk);
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        repeat (3) @(negedge clk);
        n_checks++;
        if (bus.onOff !== 1'b1) begin
            n_fail++;
            $display("FAIL async_pre: onOff=%b, expected 1", bus.onOff);
        end
        #2 reset_n = 1'b0;
        #1 check_idle_outputs("async_reset");
        @(negedge clk);
        reset_n = 1'b1;
        build(0, 1000, -1, 0, 0, 0);
        check_trace("replay_after_reset", -1, -1, 0, 0, 0);
    endtask

    task automatic test_random();
        for (int it = 0; it < 6; it++) begin
            for (int a = 0; a < 4; a++) begin
                int d = ($urandom_range(0, 4) == 0) ? 0 : int'($urandom_range(1, 3));
                write_entry(a, $urandom, d);
            end
            build(0, 1000, -1, 0, 0, 0);
            check_trace($sformatf("random_%0d", it), -1, -1, 0, 0, 0);
        end
    endtask

    initial begin
        bus.wr_en = 1'b0; bus.wr_addr = '0; bus.wr_freq = '0; bus.wr_dur = '0;
        bus.start = 1'b0; bus.stop = 1'b0; bus.loop = 1'b0;
        test_reset();
        test_normal();
        test_full_table();
        test_loop_stop();
        test_marker_loop();
        test_start_stop();
        test_midwrite();
        test_async_reset();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/melody_player.md
MELODY_PLAYER -- requirements
Module: melody_player

Interface
REQ-001 Parameter FCLK, default 50000000, clock frequency in Hz; one millisecond is MS_CYC = FCLK/1000 cycles.
REQ-002 Parameter NOTES, default 16, note-table depth; power of 2, at least 2; AW = log2(NOTES).
REQ-003 Parameter GAP_CYC, default FCLK/50, silent cycles between notes; at least 1.
REQ-004 clk  input  1  system clock, all state on rising edge.
REQ-005 reset_n  input  1  asynchronous, active-low reset.
REQ-006 wr_en  input  1  note-table write strobe.
REQ-007 wr_addr  input  AW  note-table write address.
REQ-008 wr_freq  input  32  note frequency in Hz.
REQ-009 wr_dur  input  16  note duration in ms; 0 marks end of melody.
REQ-010 start  input  1  begin playback from entry 0, sampled level.
REQ-011 stop  input  1  abort playback, sampled level.
REQ-012 loop  input  1  restart at entry 0 at melody end.
REQ-013 freq  output  32  tone frequency to the tone generator.
REQ-014 onOff  output  1  tone-generator enable.
REQ-015 busy  output  1  high in every state except IDLE.
REQ-016 done  output  1  one-cycle pulse on normal melody completion.
REQ-017 note_idx  output  AW  index of the current table entry.

Function
REQ-018 The block SHALL hold a NOTES-entry table of {freq[31:0], dur[15:0]}, written synchronously when wr_en=1 in any state.
REQ-019 A table write SHALL NOT alter a note already loaded; the new entry applies from its next LOAD.
REQ-020 FSM states SHALL be IDLE, LOAD, PLAY and GAP.
REQ-021 IDLE: freq=0 and onOff=0; start=1 (with stop=0) SHALL set note_idx=0 and go to LOAD the next cycle.
REQ-022 LOAD (1 cycle): if dur!=0, latch freq and dur, clear the ms prescaler and cycle counters, and go to PLAY.
REQ-023 LOAD: if dur=0, take the end-of-melody path.
REQ-024 PLAY: onOff=1 and freq=latched value; PLAY SHALL last exactly dur*MS_CYC cycles, then go to GAP.
REQ-025 GAP: onOff=0, freq held; GAP SHALL last exactly GAP_CYC cycles.
REQ-026 At GAP end: if note_idx=NOTES-1, take the end-of-melody path; otherwise note_idx+1 and go to LOAD.
REQ-027 End-of-melody path: if loop=1 and the melody has at least one nonzero-duration entry before the marker, set note_idx=0 and go to LOAD.
REQ-028 End-of-melody path otherwise: pulse done=1 for one cycle and go to IDLE; an entry-0 marker therefore never loops.
REQ-029 stop=1 in any state SHALL force IDLE the next cycle with onOff=0 and freq=0; done SHALL NOT pulse.
REQ-030 stop SHALL win over a simultaneous start.
REQ-031 start while busy SHALL be ignored.
REQ-032 Latency: start sampled at edge N gives LOAD at N+1 and onOff=1 at N+2.
REQ-033 Duration arithmetic SHALL use a counter at least 16+log2(MS_CYC) bits wide, with no overflow for dur=65535.
REQ-034 note_idx SHALL wrap only through the end-of-melody path, never by counter overflow.

Reset
REQ-035 reset_n=0 SHALL immediately force: state IDLE, freq=0, onOff=0, busy=0, done=0, note_idx=0, and all counters 0.
REQ-036 Reset SHALL NOT clear the note table; its contents after power-up are undefined.
REQ-037 Reset mid-PLAY SHALL silence onOff within the same cycle (asynchronous).

Verification (FCLK=4000 so MS_CYC=4, NOTES=4, GAP_CYC=2)
REQ-038 Normal play: table {440,2},{880,1},{0,0}, start pulse, loop=0 -> onOff high 8 cycles at freq=440, low 2, high 4 at 880, low 2, LOAD of marker, done pulse, busy=0.
REQ-039 Full table, no marker: 4 entries of dur 1 -> after entry 3 GAP, done pulses with no fifth LOAD.
REQ-040 Loop: the REQ-038 table with loop=1 -> 440 replays after the marker LOAD, done never pulses; stop -> IDLE next cycle, onOff=0, done=0.
REQ-041 Edge cases: entry 0 = {x,0} with loop=1 -> done pulse, IDLE; start and stop in the same cycle -> remains IDLE.
REQ-042 Mid-note write: write {1000,1} to entry 0 during entry 0 PLAY -> current note keeps 440/8 cycles; the next loop pass plays 1000.
REQ-043 Reset: assert reset_n=0 mid-PLAY -> all outputs at reset values asynchronously; a restart after release replays the unchanged table.
